// File: rtl/expr_sched_pkg.sv
// expr_sched_pkg: shared types and widths for the expression datapath scheduler.
package expr_sched_pkg;
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    localparam int DP_IN_W = 6;
    localparam int DP_OUT_W = 24;
    localparam int STAT_W = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter; grants the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt
);
    logic [W-1:0] idx;

    always_comb begin
        gnt = '0;
        idx = ptr;
        for (int k = 0; k < N; k++) begin
            if (req[idx] && gnt == '0) gnt[idx] = 1'b1;
            idx = (idx == W'(N - 1)) ? '0 : idx + W'(1);
        end
    end
endmodule

// File: rtl/expr_dp_scheduler.sv
// expr_dp_scheduler: round-robin sharing of one combinational expression datapath.
// Define EXPR_SCHED_STATS_EN to add per-requester completion and stall counters.
module expr_dp_scheduler
    import expr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DP_LATENCY = 2,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DP_IN_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DP_IN_W-1:0]           dp_in,
    input  logic [DP_OUT_W-1:0]          dp_out,
    output logic                         rsp_valid,
    output logic [DP_OUT_W-1:0]          rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    input  logic                         rsp_ready,
    output logic                         busy
`ifdef EXPR_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]    stat_done,
    output logic [STAT_W-1:0]            stat_stall
`endif
);
    state_t state, state_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0] ptr, gidx, id;
    logic [3:0] cnt;
    logic accept, capture, hs;

    rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) gidx = ID_W'(i);
    end

    assign accept = (state == IDLE) && |req_valid;
    assign capture = (state == EVAL) && cnt == '0;
    assign hs = (state == RESP) && rsp_valid && rsp_ready;
    // Gated by rst_n so no grant is ever visible while reset is held.
    assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
    assign busy = state != IDLE;
    assign rsp_id = id;

    always_comb begin
        state_nxt = accept ? EVAL : capture ? RESP : hs ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            id <= '0;
            dp_in <= '0;
            cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                dp_in <= req_data[gidx*DP_IN_W +: DP_IN_W];
                id <= gidx;
                ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
                cnt <= 4'(DP_LATENCY - 1);
            end
            if (state == EVAL && cnt != '0) cnt <= cnt - 4'd1;
            if (capture) begin
                rsp_data <= dp_out;
                rsp_valid <= 1'b1;
            end
            if (hs) rsp_valid <= 1'b0;
        end
    end

`ifdef EXPR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_done <= '0;
            stat_stall <= '0;
        end else begin
            if (state == RESP && !rsp_ready && stat_stall != '1)
                stat_stall <= stat_stall + STAT_W'(1);
            for (int i = 0; i < NUM_REQ; i++)
                if (hs && id == ID_W'(i) && stat_done[i*STAT_W +: STAT_W] != '1)
                    stat_done[i*STAT_W +: STAT_W] <= stat_done[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
    end
`endif
endmodule
